// File: rtl/ex_pkg.sv
// ex_pkg: shared constants for the execute stage.
//   - ALU operation codes driven on alu_control_d
//   - Branch condition codes driven on funct3_d
//   - Forwarding mux select codes driven on fwd_a_sel / fwd_b_sel
package ex_pkg;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    // Branch condition codes (funct3)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Forwarding selects; 2'b11 also selects the register value
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/ex_stage_alu.sv
// alu: purely combinational ALU for the execute stage.
//   op     in  4     operation code (see ex_pkg)
//   a, b   in  XLEN  operands
//   result out XLEN  result; wraps on overflow, 0 for undefined codes
module alu
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        // NOTE: result gets a default before the case so every path assigns
        // it; without that, an unlisted op code would infer a latch.
        result = '0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_SLL:   result = a << shamt;
            ALU_SRL:   result = a >> shamt;
            ALU_SRA:   result = $signed(a) >>> shamt;
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: pipeline execute stage.
//   Selects forwarded operands, runs the ALU, resolves branches/jumps
//   (combinational pc_src_e / pc_target_e to fetch) and registers results
//   into the EX/MEM register with stall (hold) and flush (bubble).
//   Inputs : clk, reset (async, active-high), stall_e, flush_e, ID/EX
//            operands and controls, fwd selects and forwarded data.
//   Outputs: pc_src_e, pc_target_e (combinational); *_m EX/MEM fields and
//            valid_m (registered, one-cycle latency).
module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] immediate,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] pc_plus_4_in,
    input  logic [2:0]      funct3_d,
    input  logic            jalr_d,
    input  logic            regwrite_d,
    input  logic            memwrite_d,
    input  logic            jump_d,
    input  logic            branch_d,
    input  logic            alu_src_d,
    input  logic [1:0]      result_src_d,
    input  logic [3:0]      alu_control_d,
    input  logic [1:0]      fwd_a_sel,
    input  logic [1:0]      fwd_b_sel,
    input  logic [XLEN-1:0] fwd_mem_data,
    input  logic [XLEN-1:0] fwd_wb_data,
    output logic            pc_src_e,
    output logic [XLEN-1:0] pc_target_e,
    output logic [XLEN-1:0] alu_result_m,
    output logic [XLEN-1:0] write_data_m,
    output logic [4:0]      rd_m,
    output logic [XLEN-1:0] pc_plus_4_m,
    output logic            regwrite_m,
    output logic            memwrite_m,
    output logic [1:0]      result_src_m,
    output logic            valid_m
);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] pc_e;
    logic            cond;

    // Forwarding muxes; 2'b11 falls through to the register value.
    always_comb begin
        case (fwd_a_sel)
            FWD_WB:  src_a = fwd_wb_data;
            FWD_MEM: src_a = fwd_mem_data;
            default: src_a = rs1_data;
        endcase
    end

    always_comb begin
        case (fwd_b_sel)
            FWD_WB:  fwd_b = fwd_wb_data;
            FWD_MEM: fwd_b = fwd_mem_data;
            default: fwd_b = rs2_data;
        endcase
    end

    assign src_b = alu_src_d ? immediate : fwd_b;

    alu #(.XLEN(XLEN)) u_alu (
        .op     (alu_control_d),
        .a      (src_a),
        .b      (src_b),
        .result (alu_result)
    );

    // Branch compare always uses the forwarded rs2, never the immediate.
    always_comb begin
        cond = 1'b0;
        case (funct3_d)
            F3_BEQ:  cond = (src_a == fwd_b);
            F3_BNE:  cond = (src_a != fwd_b);
            F3_BLT:  cond = ($signed(src_a) <  $signed(fwd_b));
            F3_BGE:  cond = ($signed(src_a) >= $signed(fwd_b));
            F3_BLTU: cond = (src_a <  fwd_b);
            F3_BGEU: cond = (src_a >= fwd_b);
            default: cond = 1'b0;
        endcase
    end

    assign pc_e        = pc_plus_4_in - XLEN'(4);
    assign pc_target_e = jalr_d ? ((src_a + immediate) & ~XLEN'(1))
                                : (pc_e + immediate);
    // Not gated by stall_e; the hazard unit owns that decision.
    assign pc_src_e    = jump_d | (branch_d & cond);

    // EX/MEM register: reset > flush > stall > load.
    // NOTE: sequential state uses non-blocking assignments so every field
    // samples pre-edge values; the asynchronous reset clears every field,
    // which is cheap here since there is no memory array in this register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_result_m <= '0;
            write_data_m <= '0;
            rd_m         <= '0;
            pc_plus_4_m  <= '0;
            regwrite_m   <= 1'b0;
            memwrite_m   <= 1'b0;
            result_src_m <= '0;
            valid_m      <= 1'b0;
        end else if (flush_e) begin
            alu_result_m <= '0;
            write_data_m <= '0;
            rd_m         <= '0;
            pc_plus_4_m  <= '0;
            regwrite_m   <= 1'b0;
            memwrite_m   <= 1'b0;
            result_src_m <= '0;
            valid_m      <= 1'b0;
        end else if (!stall_e) begin
            alu_result_m <= alu_result;
            write_data_m <= fwd_b;
            rd_m         <= rd_in;
            pc_plus_4_m  <= pc_plus_4_in;
            regwrite_m   <= regwrite_d;
            memwrite_m   <= memwrite_d;
            result_src_m <= result_src_d;
            valid_m      <= 1'b1;
        end
    end

endmodule
